crc32_check: RTL

- Receive-side companion of the CRC generator: takes a data word plus its transmitted CRC and recomputes the CRC bit-serially.
- Reports pass/fail and the error syndrome, using the same polynomial convention as the generator: plain remainder of data·x^WIDTH mod P, with no initial value, no reflection and no final XOR.
- Sits after the link/receive buffer. Uses a valid/ready handshake on both sides so it can be stalled by downstream.

---
 rtl/crc32_check_pkg.sv | 13 +
 rtl/crc32_check_if.sv | 25 ++
 rtl/crc32_check_lfsr_step.sv | 16 +
 rtl/crc32_check.sv | 101 ++++++++++
 4 files changed

// File: rtl/crc32_check_pkg.sv
// Shared types and reference polynomials for the CRC checker and its future generator sibling.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } crc_chk_state_t;

  localparam logic [32:0] CRC32_POLY = 33'h104C11DB7;
  localparam logic [8:0]  CRC8_POLY  = 9'h107;

endpackage

// File: rtl/crc32_check_if.sv
// Input word/CRC/polynomial handshake plus result handshake of the CRC checker.
interface crc32_check_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] crc_i;
  logic [WIDTH:0]   polynom_i;
  logic             result_valid;
  logic             result_ready;
  logic             crc_ok;
  logic [WIDTH-1:0] syndrome;
  logic [WIDTH-1:0] crc_calc;

  modport master (
    output in_valid, data, crc_i, polynom_i, result_ready,
    input  in_ready, result_valid, crc_ok, syndrome, crc_calc
  );

  modport slave (
    input  in_valid, data, crc_i, polynom_i, result_ready,
    output in_ready, result_valid, crc_ok, syndrome, crc_calc
  );
endinterface

// File: rtl/crc32_check_lfsr_step.sv
// One bit of MSB-first polynomial division: shifts the remainder and folds in the polynomial on feedback.
module crc_lfsr_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic [WIDTH-1:0] r_o
);
  logic fb;

  always_comb begin
    fb  = r_i[WIDTH-1] ^ bit_i;
    r_o = {r_i[WIDTH-2:0], 1'b0} ^ (fb ? poly_i : '0);
  end
endmodule

// File: rtl/crc32_check.sv
// Bit-serial CRC checker: recomputes data*x^WIDTH mod P and compares against the received CRC.
module crc32_check
  import crc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  crc32_check_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  crc_chk_state_t   state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ok_q, ok_d;
  logic [WIDTH-1:0] syn_q, syn_d;
  logic [WIDTH-1:0] calc_q, calc_d;
  logic [WIDTH-1:0] r_next;

  crc_lfsr_step #(.WIDTH(WIDTH)) u_step (
    .r_i    (r_q),
    .bit_i  (data_q[WIDTH-1]),
    .poly_i (poly_q),
    .r_o    (r_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      crc_q   <= '0;
      poly_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      syn_q   <= '0;
      calc_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      poly_q  <= poly_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      syn_q   <= syn_d;
      calc_q  <= calc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    crc_d   = crc_q;
    poly_d  = poly_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    syn_d   = syn_q;
    calc_d  = calc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.data;
          crc_d   = bus.crc_i;
          poly_d  = bus.polynom_i[WIDTH-1:0];
          r_d     = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d    = r_next;
        data_d = {data_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          calc_d  = r_next;
          syn_d   = r_next ^ crc_q;
          ok_d    = (r_next == crc_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result handshake is decoded from state so reset clears it asynchronously.
  assign bus.in_ready     = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.crc_ok       = ok_q;
  assign bus.syndrome     = syn_q;
  assign bus.crc_calc     = calc_q;
endmodule
